// File: rtl/ifetch_queue.sv
// Instruction fetch queue: issues PCs to instruction memory, pairs in-order
// responses with their PCs, and buffers (pc, instr) pairs for decode.
module ifetch_queue #(
  parameter int DEPTH   = 2,
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_in,
  input  logic               pc_valid,
  output logic               pc_ready,
  input  logic               flush,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [INSTR_W-1:0] id_instr,
  output logic               resp_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW+1:0] OCC_LIMIT = (CW+2)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pcq_mem [DEPTH];
  logic [PW-1:0]     pcq_wr, pcq_rd;
  logic [CW-1:0]     pcq_cnt;

  entry_t            fifo_mem [DEPTH];
  logic [PW-1:0]     fifo_wr, fifo_rd;
  logic [CW-1:0]     fifo_cnt;

  logic [CW-1:0]     drop_cnt;
  logic [CW-1:0]     owed;
  logic [CW+1:0]     occ;
  logic              credit;
  logic              drop_resp, accept_resp, spurious;
  logic              pop;
  entry_t            head;

  // Credit covers every slot a response could eventually need, so a
  // response push can never find the FIFO full.
  assign occ    = {2'b00, pcq_cnt} + {2'b00, drop_cnt} + {2'b00, fifo_cnt};
  assign credit = occ < OCC_LIMIT;
  assign owed   = drop_cnt + pcq_cnt;

  assign imem_req  = rst & pc_valid & credit & ~flush;
  assign imem_addr = pc_in;
  assign pc_ready  = imem_req & imem_gnt;

  assign drop_resp   = imem_rvalid & (drop_cnt != '0);
  assign accept_resp = imem_rvalid & (drop_cnt == '0) & (pcq_cnt != '0);
  assign spurious    = imem_rvalid & (drop_cnt == '0) & (pcq_cnt == '0);

  assign id_valid = fifo_cnt != '0;
  assign pop      = id_valid & id_ready;
  assign head     = fifo_mem[fifo_rd];
  assign id_pc    = id_valid ? head.pc    : '0;
  assign id_instr = id_valid ? head.instr : '0;

  // NOTE: storage arrays carry no reset; counts and pointers alone define
  // which words are live, and outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (pc_ready) pcq_mem[pcq_wr] <= pc_in;
    if (accept_resp && !flush) fifo_mem[fifo_wr] <= '{pc: pcq_mem[pcq_rd], instr: imem_rdata};
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcq_wr   <= '0;
      pcq_rd   <= '0;
      pcq_cnt  <= '0;
      drop_cnt <= '0;
      resp_err <= 1'b0;
    end else if (flush) begin
      pcq_wr  <= '0;
      pcq_rd  <= '0;
      pcq_cnt <= '0;
      // A response landing in the flush cycle pays off one owed slot.
      if (imem_rvalid && owed != '0) drop_cnt <= owed - CW'(1);
      else                           drop_cnt <= owed;
      if (imem_rvalid && owed == '0) resp_err <= 1'b1;
    end else begin
      if (pc_ready)    pcq_wr <= pcq_wr + PW'(1);
      if (accept_resp) pcq_rd <= pcq_rd + PW'(1);
      case ({pc_ready, accept_resp})
        2'b10:   pcq_cnt <= pcq_cnt + CW'(1);
        2'b01:   pcq_cnt <= pcq_cnt - CW'(1);
        default: pcq_cnt <= pcq_cnt;
      endcase
      if (drop_resp) drop_cnt <= drop_cnt - CW'(1);
      if (spurious)  resp_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
    end else if (flush) begin
      fifo_wr  <= '0;
      fifo_rd  <= '0;
      fifo_cnt <= '0;
    end else begin
      if (accept_resp) fifo_wr <= fifo_wr + PW'(1);
      if (pop)         fifo_rd <= fifo_rd + PW'(1);
      case ({accept_resp, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: in-order memory model, scoreboard of
// expected decode entries, and directed plus randomized phases.
module tb_ifetch_queue;
  localparam int DEPTH   = 2;
  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  logic               clk, rst;
  logic [ADDR_W-1:0]  pc_in;
  logic               pc_valid, pc_ready, flush;
  logic               imem_req, imem_gnt, imem_rvalid;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               id_valid, id_ready, resp_err;
  logic [ADDR_W-1:0]  id_pc;
  logic [INSTR_W-1:0] id_instr;

  ifetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
    .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } pair_t;
  typedef struct {
    logic [ADDR_W-1:0] pc;
    bit                killed;
  } req_t;

  req_t              pending[$];   // requests the memory still owes a response for
  pair_t             exp_q[$];     // scoreboard: entries decode must see, in order
  pair_t             seen[$];      // entries decode actually took
  logic [ADDR_W-1:0] pc_src[$];    // PCs the PC adder wants to issue

  int  checks = 0, passed = 0;
  bit  err_exp = 1'b0;
  int  issued = 0, seq = 0;
  int  ready_mode = 0, gnt_mode = 0, resp_mode = 0;
  bit  flush_req = 1'b0, spur_req = 1'b0;
  bit  cur_resp_real = 1'b0;
  req_t cur_resp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit pick(input int m);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return 1'($urandom % 2);
      default: return ($urandom % 4) != 0;
    endcase
  endfunction

  // Driver and in-order memory: inputs change 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    id_ready    = pick(ready_mode);
    imem_gnt    = pick(gnt_mode);
    flush       = flush_req;
    pc_valid    = pc_src.size() > 0;
    pc_in       = pc_valid ? pc_src[0] : '0;
    imem_rvalid = 1'b0;
    cur_resp_real = 1'b0;
    if (spur_req) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_0000;
    end else if (rst && pending.size() > 0 && pick(resp_mode)) begin
      cur_resp      = pending.pop_front();
      cur_resp_real = 1'b1;
      imem_rvalid   = 1'b1;
      seq++;
      imem_rdata    = (cur_resp.pc == 64'h100) ? 32'h0000_BEEF : 32'hAAAA_0000 + 32'(seq);
    end
  end

  // Monitor and reference model, evaluated mid-cycle on the falling edge.
  always @(negedge clk) begin
    bit exp_req;
    if (!rst) begin
      pending.delete();
      exp_q.delete();
      err_exp = 1'b0;
    end else begin
      // Everything owed or buffered counts against the DEPTH slots.
      exp_req = pc_valid && !flush &&
                (pending.size() + int'(cur_resp_real) + exp_q.size() < DEPTH);
      check("imem_req", imem_req, exp_req);
      check("pc_ready", pc_ready, exp_req && imem_gnt);
      check("id_valid", id_valid, exp_q.size() > 0);
      check("resp_err", resp_err, err_exp);
      if (exp_q.size() > 0) begin
        check("id_pc", id_pc, exp_q[0].pc);
        check("id_instr", id_instr, exp_q[0].instr);
      end
      if (!flush && id_valid && id_ready) begin
        seen.push_back('{pc: id_pc, instr: id_instr});
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (imem_rvalid && !cur_resp_real) err_exp = 1'b1;
      if (flush) begin
        exp_q.delete();
        foreach (pending[i]) pending[i].killed = 1'b1;
      end else if (imem_rvalid && cur_resp_real && !cur_resp.killed) begin
        exp_q.push_back('{pc: cur_resp.pc, instr: imem_rdata});
      end
      if (exp_req && imem_gnt) begin
        pending.push_back('{pc: pc_in, killed: 1'b0});
        void'(pc_src.pop_front());
        issued++;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (pc_src.size() == 0 && pending.size() == 0 && exp_q.size() == 0) return;
    end
    check("idle_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_pending(input int n);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (pending.size() == n) return;
    end
    check("pending_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; pc_valid = 1'b1; pc_in = 64'h28; imem_gnt = 1'b1; flush = 1'b0;
    imem_rvalid = 1'b0; imem_rdata = '0; id_ready = 1'b0;
    #2;
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_pc_ready", pc_ready, 1'b0);
    check("rst_id_valid", id_valid, 1'b0);
    check("rst_id_pc", id_pc, 64'h0);
    check("rst_id_instr", id_instr, 32'h0);
    check("rst_resp_err", resp_err, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    // Streaming
    gnt_mode = 1; resp_mode = 1; ready_mode = 1;
    seen.delete();
    pc_src.push_back(64'h28); pc_src.push_back(64'h2C); pc_src.push_back(64'h30);
    wait_idle();
    check("stream_count", seen.size(), 3);
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      check("stream_pc", seen[i].pc, 64'h28 + 64'(4 * i));
      check("stream_instr", seen[i].instr, 32'hAAAA_0001 + 32'(i));
    end

    // Backpressure
    ready_mode = 0; seen.delete(); issued = 0;
    for (int i = 0; i < 6; i++) pc_src.push_back(64'h28 + 64'(4 * i));
    repeat (10) @(posedge clk);
    #2;
    check("bp_issued", issued, DEPTH);
    check("bp_imem_req", imem_req, 1'b0);
    check("bp_pc_ready", pc_ready, 1'b0);
    check("bp_head_pc", id_pc, 64'h28);
    ready_mode = 1;
    wait_idle();
    check("bp_count", seen.size(), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++)
      check("bp_order", seen[i].pc, 64'h28 + 64'(4 * i));

    // Flush with two requests in flight
    seen.delete(); resp_mode = 0;
    pc_src.push_back(64'h40); pc_src.push_back(64'h44);
    wait_pending(2);
    flush_req = 1'b1;
    @(posedge clk);
    flush_req = 1'b0; resp_mode = 1;
    pc_src.push_back(64'h100);
    @(negedge clk);
    check("flush_id_valid_next", id_valid, 1'b0);
    wait_idle();
    check("flush_count", seen.size(), 1);
    if (seen.size() > 0) begin
      check("flush_pc", seen[0].pc, 64'h100);
      check("flush_instr", seen[0].instr, 32'h0000_BEEF);
    end

    // Flush coinciding with pc_valid and a response
    seen.delete(); resp_mode = 0;
    pc_src.push_back(64'h200); pc_src.push_back(64'h204);
    wait_pending(2);
    flush_req = 1'b1; resp_mode = 1;
    pc_src.push_back(64'h300);
    #2;
    check("flush_cycle_req", imem_req, 1'b0);
    check("flush_cycle_rvalid", imem_rvalid, 1'b1);
    @(posedge clk);
    flush_req = 1'b0;
    wait_idle();
    check("flush2_count", seen.size(), 1);
    if (seen.size() > 0) check("flush2_pc", seen[0].pc, 64'h300);

    // Spurious response
    spur_req = 1'b1;
    @(posedge clk);
    spur_req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("spur_err", resp_err, 1'b1);
    check("spur_fifo", id_valid, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("spur_err_cleared", resp_err, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;

    // Asynchronous reset with one buffered entry
    ready_mode = 0;
    pc_src.push_back(64'h500);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (exp_q.size() == 1 && pending.size() == 0) break;
    end
    pc_src.push_back(64'h504);
    #3;
    check("pre_rst_id_valid", id_valid, 1'b1);
    check("pre_rst_imem_req", imem_req, 1'b1);
    #1 rst = 1'b0;
    #1;
    check("async_id_valid", id_valid, 1'b0);
    check("async_imem_req", imem_req, 1'b0);
    check("async_pc_ready", pc_ready, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    ready_mode = 1;
    wait_idle();

    // Randomized traffic with occasional flushes
    ready_mode = 2; gnt_mode = 2; resp_mode = 3;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      if (pc_src.size() < 3) pc_src.push_back({$urandom, $urandom} & ~64'h3);
      flush_req = ($urandom % 16) == 0;
    end
    @(posedge clk);
    flush_req = 1'b0; ready_mode = 1; gnt_mode = 1; resp_mode = 1;
    wait_idle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Fetch stage directly downstream of the PC adder.
- Takes each 64-bit PC the PC adder produces and issues it as a request to the instruction memory.
- Pairs each in-order memory response with the PC that requested it, and buffers the pairs in a small FIFO.
- Presents (pc, instruction) to decode with a valid/ready handshake; a branch-taken flush discards all younger work, including responses still in flight.

Parameters:
- DEPTH, 2: max combined count of live in-flight requests + to-be-dropped responses + buffered entries; power of two, ≥2.
- ADDR_W, 64: PC/address width.
- INSTR_W, 32: instruction word width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- pc_in  input  ADDR_W  PC from the PC adder.
- pc_valid  input  1  pc_in valid.
- pc_ready  output  1  pc_in accepted this cycle.
- flush  input  1  branch taken (zero_en & brnch_en upstream); kills all younger work.
- imem_req  output  1  memory request valid.
- imem_addr  output  ADDR_W  request address, equals pc_in.
- imem_gnt  input  1  memory accepts the request this cycle.
- imem_rvalid  input  1  response valid; responses return in request order, one per cycle maximum.
- imem_rdata  input  INSTR_W  response instruction.
- id_valid  output  1  decode entry valid.
- id_ready  input  1  decode accepts the entry.
- id_pc  output  ADDR_W  PC of the head entry.
- id_instr  output  INSTR_W  instruction of the head entry.
- resp_err  output  1  sticky error: a response arrived with nothing outstanding.

Behaviour:
- State:
  - pc queue: DEPTH entries, PCs of live in-flight requests.
  - instr FIFO: DEPTH entries of {pc, instr}.
  - drop_cnt: 0..DEPTH, responses still owed to flushed requests.
- Credit: credit = (live_inflight + drop_cnt + fifo_count) < DEPTH, computed from registered state only.
- Request path (combinational):
  - imem_req = pc_valid & credit & ~flush.
  - imem_addr = pc_in.
  - pc_ready = imem_req & imem_gnt.
  - On pc_ready, pc_in is pushed to the pc queue at the clock edge.
- Response path:
  - When imem_rvalid and drop_cnt>0: discard the response, drop_cnt decrements.
  - When imem_rvalid, drop_cnt==0 and the pc queue is non-empty: pop the pc queue head and push {head pc, imem_rdata} into the instr FIFO at the same edge. Response-to-id_valid latency is 1 cycle.
  - Credit accounting guarantees the FIFO is never full on a push; no overflow path exists.
- Decode path:
  - id_valid = fifo non-empty.
  - id_pc/id_instr show the head entry; they hold stable while id_valid & ~id_ready.
  - Pop on id_valid & id_ready.
- Simultaneous events:
  - Pop and push in the same cycle: both occur, count unchanged.
  - Issue and response in the same cycle: the pc queue pushes and pops together.
- Flush, effective at the clock edge:
  - The instr FIFO and pc queue are cleared; id_valid is 0 the next cycle.
  - drop_cnt becomes drop_cnt + live_inflight − (1 if imem_rvalid that cycle), so a response arriving in the flush cycle is itself discarded.
  - No request is issued in the flush cycle (imem_req=0).
  - A decode pop in the flush cycle is irrelevant; the entry is gone either way.
  - New requests may issue from the next cycle, subject to credit; because responses are in order, the drops are consumed first.
- Error:
  - imem_rvalid with drop_cnt==0 and an empty pc queue sets resp_err; the response is ignored.
  - resp_err clears only on reset.
- Reset (rst=0, asynchronous):
  - Queues empty; drop_cnt=0; resp_err=0; id_valid=0.
  - pc_ready=0 and imem_req=0 while rst is low.
  - id_pc/id_instr = 0.
  - Reset mid-operation abandons all in-flight requests; the memory is reset by the same rst.
- Pointers wrap modulo DEPTH. Counters are $clog2(DEPTH)+1 bits wide.

Test Plan:
- Streaming:
  - Stimulus: PCs 0x28, 0x2C, 0x30; memory grants every cycle and responds 1 cycle later with 0xAAAA0001.., id_ready=1.
  - Required: decode sees (0x28,0xAAAA0001), (0x2C,0xAAAA0002), (0x30,0xAAAA0003) in order, one per cycle after the fill latency.
- Backpressure:
  - Stimulus: id_ready=0 with a continuous pc_valid.
  - Required: exactly DEPTH=2 requests issue, then pc_ready=0 and imem_req=0; the head (0x28) holds stable; after id_ready=1, issue resumes with no loss or duplication.
- Flush with in-flight work:
  - Stimulus: 2 requests outstanding, flush pulses for 1 cycle, then PC 0x100 with instruction 0xBEEF.
  - Required: the two old responses are dropped (drop_cnt 2→0); the first decode entry after the flush is (0x100,0xBEEF); id_valid=0 in the cycle after the flush.
- Flush coinciding with pc_valid and rvalid:
  - Required: imem_req=0 that cycle; the arriving response is discarded; drop_cnt equals the remaining live in-flight count.
- Spurious response:
  - Stimulus: imem_rvalid with nothing outstanding.
  - Required: resp_err=1 and stays 1, the FIFO is unchanged; rst low then high clears it to 0.
- Asynchronous reset mid-stream:
  - Stimulus: assert rst between clock edges with the FIFO holding 1 entry.
  - Required: id_valid, imem_req and pc_ready drop to 0 immediately, without waiting for a clock edge.
